// File: rtl/apu_noise_regif_if.sv
// rtl/apu_noise_regif_if.sv - CPU-side request/ack bus for the APU noise register writer
interface apu_noise_regif_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/apu_noise_regif.sv
// rtl/apu_noise_regif.sv - noise channel register writer ($400C/E/F, $4015, $4017)
// Optional macro APU_NOISE_REGIF_READBACK_EN: reads of $400C/E/F return the latched registers.
module apu_noise_regif #(
  parameter logic [15:0] BASE_ADDR     = 16'h4000,
  parameter logic [7:0]  OPEN_BUS_INIT = 8'h40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  apu_noise_regif_if.slave         bus,
  output logic [7:0]               r400c,
  output logic [7:0]               r400e,
  output logic [7:0]               r400f,
  output logic                     noise_en,
  output logic                     frame_mode,
  output logic                     irq_inhibit,
  output logic                     wr_400e_stb,
  output logic                     wr_400f_stb,
  output logic                     len_clear_stb,
  output logic                     frame_reset_stb,
  output logic                     frame_irq_clr_stb,
  input  logic                     noise_len_active,
  input  logic                     frame_irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  open_bus_q, open_bus_d;
  logic [7:0]  r400c_q, r400c_d;
  logic [7:0]  r400e_q, r400e_d;
  logic [7:0]  r400f_q, r400f_d;
  logic        noise_en_q, noise_en_d;
  logic        frame_mode_q, frame_mode_d;
  logic        irq_inhibit_q, irq_inhibit_d;

  logic        in_win;
  logic [4:0]  offset;

  assign in_win = (addr_q[15:5] == BASE_ADDR[15:5]);
  assign offset = addr_q[4:0];

  always_comb begin
    state_d           = state_q;
    we_d              = we_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    open_bus_d        = open_bus_q;
    r400c_d           = r400c_q;
    r400e_d           = r400e_q;
    r400f_d           = r400f_q;
    noise_en_d        = noise_en_q;
    frame_mode_d      = frame_mode_q;
    irq_inhibit_d     = irq_inhibit_q;
    wr_400e_stb       = 1'b0;
    wr_400f_stb       = 1'b0;
    len_clear_stb     = 1'b0;
    frame_reset_stb   = 1'b0;
    frame_irq_clr_stb = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          state_d = ST_ACCESS;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
        end
      end
      // Strobes are decoded from the held access, so they live only in ACCESS
      // and vanish with the async reset if an access is aborted.
      ST_ACCESS: begin
        state_d = ST_ACK;
        if (we_q) begin
          open_bus_d = wdata_q;
          if (in_win) begin
            case (offset)
              5'h0C: r400c_d = wdata_q;
              5'h0E: begin
                r400e_d     = wdata_q;
                wr_400e_stb = 1'b1;
              end
              5'h0F: begin
                r400f_d     = wdata_q;
                wr_400f_stb = 1'b1;
              end
              5'h15: begin
                noise_en_d    = wdata_q[3];
                len_clear_stb = ~wdata_q[3];
              end
              5'h17: begin
                frame_mode_d      = wdata_q[7];
                irq_inhibit_d     = wdata_q[6];
                frame_reset_stb   = 1'b1;
                frame_irq_clr_stb = wdata_q[6];
              end
              default: ;
            endcase
          end
        end else begin
          rdata_d = open_bus_q;
          if (in_win) begin
            case (offset)
              5'h15: begin
                rdata_d = {1'b0, frame_irq, open_bus_q[5], 1'b0,
                           noise_len_active, 3'b000};
                frame_irq_clr_stb = 1'b1;
              end
`ifdef APU_NOISE_REGIF_READBACK_EN
              5'h0C: rdata_d = r400c_q;
              5'h0E: rdata_d = r400e_q;
              5'h0F: rdata_d = r400f_q;
`else
`endif
              default: ;
            endcase
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      addr_q        <= 16'h0000;
      wdata_q       <= 8'h00;
      rdata_q       <= 8'h00;
      open_bus_q    <= OPEN_BUS_INIT;
      r400c_q       <= 8'h00;
      r400e_q       <= 8'h00;
      r400f_q       <= 8'h00;
      noise_en_q    <= 1'b0;
      frame_mode_q  <= 1'b0;
      irq_inhibit_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      open_bus_q    <= open_bus_d;
      r400c_q       <= r400c_d;
      r400e_q       <= r400e_d;
      r400f_q       <= r400f_d;
      noise_en_q    <= noise_en_d;
      frame_mode_q  <= frame_mode_d;
      irq_inhibit_q <= irq_inhibit_d;
    end
  end

  assign bus.cpu_ack   = (state_q == ST_ACK);
  assign bus.cpu_rdata = rdata_q;
  assign r400c         = r400c_q;
  assign r400e         = r400e_q;
  assign r400f         = r400f_q;
  assign noise_en      = noise_en_q;
  assign frame_mode    = frame_mode_q;
  assign irq_inhibit   = irq_inhibit_q;

endmodule

// File: tb/tb_apu_noise_regif.sv
// tb/tb_apu_noise_regif.sv - scoreboard bench for the APU noise register writer
module tb_apu_noise_regif;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] r400c, r400e, r400f;
  logic noise_en, frame_mode, irq_inhibit;
  logic wr_400e_stb, wr_400f_stb, len_clear_stb, frame_reset_stb, frame_irq_clr_stb;
  logic noise_len_active, frame_irq;

  apu_noise_regif_if bus();

  apu_noise_regif dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .r400c             (r400c),
    .r400e             (r400e),
    .r400f             (r400f),
    .noise_en          (noise_en),
    .frame_mode        (frame_mode),
    .irq_inhibit       (irq_inhibit),
    .wr_400e_stb       (wr_400e_stb),
    .wr_400f_stb       (wr_400f_stb),
    .len_clear_stb     (len_clear_stb),
    .frame_reset_stb   (frame_reset_stb),
    .frame_irq_clr_stb (frame_irq_clr_stb),
    .noise_len_active  (noise_len_active),
    .frame_irq         (frame_irq)
  );

  always #5 clk = ~clk;

  // strobe bit order: {frame_irq_clr, frame_reset, len_clear, wr_400f, wr_400e}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_400E = 5'b00001;
  localparam logic [4:0] S_400F = 5'b00010;
  localparam logic [4:0] S_LCLR = 5'b00100;
  localparam logic [4:0] S_FRST = 5'b01000;
  localparam logic [4:0] S_ICLR = 5'b10000;

  typedef struct packed {
    logic [7:0] rd;
    logic       chk_rd;
    logic [4:0] stb;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] strobes();
    return {frame_irq_clr_stb, frame_reset_stb, len_clear_stb, wr_400f_stb, wr_400e_stb};
  endfunction

  task automatic access(input string tag, input logic we, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input logic [4:0] exp_stb);
    logic [4:0] seen, dup, s;
    logic [7:0] rd;
    sb_t        e;
    int         cyc;
    sb_q.push_back('{rd: exp_rd, chk_rd: ~we, stb: exp_stb});
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    seen = '0; dup = '0; cyc = 1;
    while (!bus.cpu_ack && cyc < 8) begin
      s = strobes();
      dup |= seen & s;
      seen |= s;
      @(negedge clk);
      cyc++;
    end
    rd = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    s = strobes();
    dup |= seen & s;
    seen |= s;
    e = sb_q.pop_front();
    check_eq({tag, "_lat"}, cyc, 3);
    check_eq({tag, "_stb"}, seen, e.stb);
    check_eq({tag, "_stb_once"}, dup, 0);
    if (e.chk_rd) check_eq({tag, "_rdata"}, rd, e.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_rb;
    int bad;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    noise_len_active = 1'b0; frame_irq = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_regs", {r400c, r400e, r400f}, 24'h0);
    check_eq("rst_flags", {noise_en, frame_mode, irq_inhibit}, 3'b000);
    check_eq("rst_stb", strobes(), 5'b0);
    check_eq("rst_ack_rdata", {bus.cpu_ack, bus.cpu_rdata}, 9'h0);
    rst_n = 1'b1;

    access("rd_ob_init", 1'b0, 16'h4000, 8'h00, 8'h40, S_NONE);
    access("wr_400e", 1'b1, 16'h400E, 8'h8A, 8'h00, S_400E);
    check_eq("r400e", r400e, 8'h8A);
    access("wr_400c", 1'b1, 16'h400C, 8'h3F, 8'h00, S_NONE);
    check_eq("r400c", r400c, 8'h3F);
    access("wr_400d", 1'b1, 16'h400D, 8'hFF, 8'h00, S_NONE);
    check_eq("r400d_noeff", {r400c, r400e, r400f}, 24'h3F8A00);

    access("wr_4015_on", 1'b1, 16'h4015, 8'h08, 8'h00, S_NONE);
    check_eq("noise_en_on", noise_en, 1'b1);
    access("wr_4015_off", 1'b1, 16'h4015, 8'h00, 8'h00, S_LCLR);
    check_eq("noise_en_off", noise_en, 1'b0);

    access("wr_ob20", 1'b1, 16'h4000, 8'h20, 8'h00, S_NONE);
    noise_len_active = 1'b1; frame_irq = 1'b1;
    access("rd_4015", 1'b0, 16'h4015, 8'h00, 8'h68, S_ICLR);
    noise_len_active = 1'b0; frame_irq = 1'b0;
    access("rd_ob20", 1'b0, 16'h4003, 8'h00, 8'h20, S_NONE);
`ifdef APU_NOISE_REGIF_READBACK_EN
    exp_rb = 8'h8A;
`else
    exp_rb = 8'h20;
`endif
    access("rd_400e", 1'b0, 16'h400E, 8'h00, exp_rb, S_NONE);

    access("wr_4017_c0", 1'b1, 16'h4017, 8'hC0, 8'h00, S_FRST | S_ICLR);
    check_eq("frame_bits_c0", {frame_mode, irq_inhibit}, 2'b11);
    access("wr_4017_80", 1'b1, 16'h4017, 8'h80, 8'h00, S_FRST);
    check_eq("frame_bits_80", {frame_mode, irq_inhibit}, 2'b10);

    access("wr_outside", 1'b1, 16'h5015, 8'h08, 8'h00, S_NONE);
    check_eq("outside_noeff", noise_en, 1'b0);
    access("rd_ob08", 1'b0, 16'h4001, 8'h00, 8'h08, S_NONE);

    access("wr_400f_a", 1'b1, 16'h400F, 8'h11, 8'h00, S_400F);
    access("wr_400f_b", 1'b1, 16'h400F, 8'h22, 8'h00, S_400F);
    check_eq("r400f_last", r400f, 8'h22);
    access("rd_4015_idle", 1'b0, 16'h4015, 8'h00, 8'h20, S_ICLR);

    // abort a $400F write with reset while it is in ACCESS
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h400F; bus.cpu_wdata = 8'h55;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.cpu_ack || (strobes() != 5'b0)) bad++;
    end
    check_eq("rst_abort_quiet", bad, 0);
    check_eq("rst_abort_r400f", r400f, 8'h00);
    check_eq("rst_abort_regs", {r400c, r400e, frame_mode}, 17'h0);
    rst_n = 1'b1;
`ifdef APU_NOISE_REGIF_READBACK_EN
    exp_rb = 8'h00;
`else
    exp_rb = 8'h40;
`endif
    access("rd_400f_post", 1'b0, 16'h400F, 8'h00, exp_rb, S_NONE);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
